// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for two valid/ready sources feeding a 2:1 mux.
// Bursts framed by *_last are kept whole; the winning beat is registered to y.
module mux_rr_arbiter #(
  parameter int WIDTH     = 1,
  parameter int MAX_BEATS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_last,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_last,
  output logic             sel,
  output logic [WIDTH-1:0] y,
  output logic             y_last,
  output logic             y_src,
  output logic             y_valid,
  input  logic             y_ready
);

  localparam int CNT_W = $clog2(MAX_BEATS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS - 1);

  typedef enum logic [1:0] {IDLE, LOCK_A, LOCK_B} state_t;

  state_t           state_q, state_d;
  logic             last_win_q, last_win_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             y_last_q, y_last_d;
  logic             y_src_q, y_src_d;
  logic             y_valid_q, y_valid_d;

  logic grant_b, grant_en, can_load, xfer, win_last;

  assign can_load = !y_valid_q || y_ready;

  // Grant selection: free arbitration in IDLE, fixed owner while locked.
  always_comb begin
    grant_b  = !last_win_q;
    grant_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        grant_en = a_valid || b_valid;
        if (a_valid && b_valid) grant_b = !last_win_q;
        else if (a_valid)       grant_b = 1'b0;
        else if (b_valid)       grant_b = 1'b1;
      end
      LOCK_A: begin
        grant_en = 1'b1;
        grant_b  = 1'b0;
      end
      LOCK_B: begin
        grant_en = 1'b1;
        grant_b  = 1'b1;
      end
      default: begin
        grant_en = 1'b0;
        grant_b  = !last_win_q;
      end
    endcase
  end

  assign sel      = grant_b;
  assign a_ready  = can_load && grant_en && !grant_b;
  assign b_ready  = can_load && grant_en && grant_b;
  assign xfer     = grant_b ? (b_valid && b_ready) : (a_valid && a_ready);
  assign win_last = grant_b ? b_last : a_last;

  always_comb begin
    state_d    = state_q;
    last_win_d = last_win_q;
    cnt_d      = cnt_q;
    if (xfer) begin
      if (state_q == IDLE) begin
        if (win_last) begin
          last_win_d = grant_b;
        end else begin
          state_d = grant_b ? LOCK_B : LOCK_A;
          cnt_d   = CNT_W'(1);
        end
      end else if (win_last || cnt_q == CNT_LAST) begin
        // Forced release at MAX_BEATS keeps one source from starving the other.
        state_d    = IDLE;
        last_win_d = grant_b;
        cnt_d      = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    y_d       = y_q;
    y_last_d  = y_last_q;
    y_src_d   = y_src_q;
    y_valid_d = y_valid_q;
    if (xfer) begin
      y_d       = grant_b ? b_data : a_data;
      y_last_d  = win_last;
      y_src_d   = grant_b;
      y_valid_d = 1'b1;
    end else if (y_ready) begin
      y_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_win_q <= 1'b1;
      cnt_q      <= '0;
      y_q        <= '0;
      y_last_q   <= 1'b0;
      y_src_q    <= 1'b0;
      y_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_win_q <= last_win_d;
      cnt_q      <= cnt_d;
      y_q        <= y_d;
      y_last_q   <= y_last_d;
      y_src_q    <= y_src_d;
      y_valid_q  <= y_valid_d;
    end
  end

  assign y       = y_q;
  assign y_last  = y_last_q;
  assign y_src   = y_src_q;
  assign y_valid = y_valid_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: scenario tasks plus a reference-model scoreboard on every cycle.
module tb_mux_rr_arbiter;

  localparam int WIDTH     = 8;
  localparam int MAX_BEATS = 4;

  logic             clk;
  logic             rst;
  logic             a_valid, a_ready, a_last;
  logic [WIDTH-1:0] a_data;
  logic             b_valid, b_ready, b_last;
  logic [WIDTH-1:0] b_data;
  logic             sel;
  logic [WIDTH-1:0] y;
  logic             y_last, y_src, y_valid, y_ready;

  int total = 0;
  int bad   = 0;

  mux_rr_arbiter #(.WIDTH(WIDTH), .MAX_BEATS(MAX_BEATS)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_last(a_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data), .b_last(b_last),
    .sel(sel), .y(y), .y_last(y_last), .y_src(y_src), .y_valid(y_valid),
    .y_ready(y_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: 0 = idle, 1 = locked on A, 2 = locked on B
  int               m_state;
  logic             m_lw;
  int               m_cnt;
  logic             m_yv;
  logic [WIDTH+1:0] sb_q[$];

  logic             gb, gen, can, xf, wl;
  logic [WIDTH+1:0] exp_beat;

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      m_state = 0;
      m_lw    = 1'b1;
      m_cnt   = 0;
      m_yv    = 1'b0;
      sb_q.delete();
    end else begin
      can = !m_yv || y_ready;
      gb  = !m_lw;
      gen = 1'b0;
      if (m_state == 0) begin
        gen = a_valid || b_valid;
        if (a_valid && !b_valid) gb = 1'b0;
        if (b_valid && !a_valid) gb = 1'b1;
      end else begin
        gen = 1'b1;
        gb  = (m_state == 2);
      end
      total++;
      if (sel !== gb) begin bad++; $display("FAIL sb_sel got=%b exp=%b t=%0t", sel, gb, $time); end
      total++;
      if (a_ready !== (can && gen && !gb)) begin
        bad++; $display("FAIL sb_a_ready got=%b exp=%b t=%0t", a_ready, can && gen && !gb, $time);
      end
      total++;
      if (b_ready !== (can && gen && gb)) begin
        bad++; $display("FAIL sb_b_ready got=%b exp=%b t=%0t", b_ready, can && gen && gb, $time);
      end
      total++;
      if (y_valid !== m_yv) begin bad++; $display("FAIL sb_y_valid got=%b exp=%b t=%0t", y_valid, m_yv, $time); end
      if (m_yv && y_ready) begin
        total++;
        if (sb_q.size() == 0) begin
          bad++; $display("FAIL sb_extra_beat got=%h exp=none t=%0t", y, $time);
        end else begin
          exp_beat = sb_q.pop_front();
          if ({y_src, y_last, y} !== exp_beat) begin
            bad++; $display("FAIL sb_beat got=%h exp=%h t=%0t", {y_src, y_last, y}, exp_beat, $time);
          end
        end
      end
      xf = gen && can && (gb ? b_valid : a_valid);
      wl = gb ? b_last : a_last;
      if (xf) begin
        sb_q.push_back({gb, wl, gb ? b_data : a_data});
        if (m_state == 0) begin
          if (wl) m_lw = gb;
          else begin m_state = gb ? 2 : 1; m_cnt = 1; end
        end else if (wl || m_cnt == MAX_BEATS - 1) begin
          m_state = 0; m_lw = gb; m_cnt = 0;
        end else begin
          m_cnt++;
        end
        m_yv = 1'b1;
      end else if (y_ready) begin
        m_yv = 1'b0;
      end
    end
  end

  task automatic idle_inputs();
    a_valid = 0; a_last = 0; a_data = '0;
    b_valid = 0; b_last = 0; b_data = '0;
    y_ready = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    idle_inputs();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++;
    if ({y_valid, y, y_last, y_src, sel, a_ready, b_ready} !== '0) begin
      bad++; $display("FAIL reset_state got=%h exp=0", {y_valid, y, y_last, y_src, sel, a_ready, b_ready});
    end
    @(posedge clk); #1;
    b_valid = 1; b_last = 0; b_data = 8'h77; y_ready = 1;
    @(posedge clk); #1;
    a_valid = 1; a_last = 1; a_data = 8'h11;
    @(negedge clk);
    total++;
    if ({sel, a_ready, y_valid, y_src} !== 4'b1011) begin
      bad++; $display("FAIL reset_lock_b got=%b exp=1011", {sel, a_ready, y_valid, y_src});
    end
    #2 rst = 1;
    #1;
    total++;
    if ({y_valid, sel, y} !== '0) begin
      bad++; $display("FAIL reset_async got=%h exp=0", {y_valid, sel, y});
    end
    @(posedge clk); #1;
    rst = 0;
    b_last = 1;
    @(negedge clk);
    total++;
    if ({sel, a_ready, b_ready} !== 3'b010) begin
      bad++; $display("FAIL reset_release got=%b exp=010", {sel, a_ready, b_ready});
    end
  endtask

  task automatic test_tie();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      a_valid = 1; a_last = 1; a_data = 8'h10 + 8'(i);
      b_valid = 1; b_last = 1; b_data = 8'h20 + 8'(i);
      y_ready = 1;
      @(negedge clk);
      if (i > 0) begin
        total++;
        if ({y_valid, y_src} !== {1'b1, 1'((i - 1) % 2)}) begin
          bad++; $display("FAIL tie_alt i=%0d got=%b exp=%b", i, {y_valid, y_src}, {1'b1, 1'((i - 1) % 2)});
        end
      end
    end
  endtask

  task automatic test_burst_lock();
    logic [3:0] exp_src;
    exp_src = 4'b1000;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      a_valid = 1; a_last = (i == 2); a_data = 8'h30 + 8'(i);
      b_valid = 1; b_last = 1;        b_data = 8'h40 + 8'(i);
      y_ready = 1;
      @(negedge clk);
      if (i < 3) begin
        total++;
        if (b_ready !== 1'b0) begin bad++; $display("FAIL burst_b_stall i=%0d got=%b exp=0", i, b_ready); end
      end
      if (i > 0) begin
        total++;
        if (y_src !== exp_src[i - 1]) begin
          bad++; $display("FAIL burst_src i=%0d got=%b exp=%b", i, y_src, exp_src[i - 1]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      a_valid = 1; a_last = 1; a_data = 8'hA0 + 8'(i);
      b_valid = 1; b_last = 1; b_data = 8'hB0 + 8'(i);
      y_ready = !(i >= 2 && i <= 5);
      @(negedge clk);
      if (i >= 2 && i <= 5) begin
        total++;
        if ({y_valid, y_src, y, a_ready, b_ready} !== {1'b1, 1'b1, 8'hB1, 2'b00}) begin
          bad++; $display("FAIL bp_frozen i=%0d got=%h exp=%h", i, {y_valid, y_src, y, a_ready, b_ready},
                          {1'b1, 1'b1, 8'hB1, 2'b00});
        end
      end
      if (i == 7) begin
        total++;
        if ({y_src, y} !== {1'b0, 8'hA6}) begin
          bad++; $display("FAIL bp_resume got=%h exp=%h", {y_src, y}, {1'b0, 8'hA6});
        end
      end
    end
  endtask

  task automatic test_forced_release();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      a_valid = 1; a_last = 0; a_data = 8'h50 + 8'(i);
      b_valid = 1; b_last = 1; b_data = 8'h60 + 8'(i);
      y_ready = 1;
      @(negedge clk);
      if (i == 4) begin
        total++;
        if ({y_src, y_last, y} !== {2'b00, 8'h53}) begin
          bad++; $display("FAIL force_4th got=%h exp=%h", {y_src, y_last, y}, {2'b00, 8'h53});
        end
        total++;
        if ({sel, a_ready, b_ready} !== 3'b101) begin
          bad++; $display("FAIL force_grant got=%b exp=101", {sel, a_ready, b_ready});
        end
      end
      if (i == 5) begin
        total++;
        if ({y_src, y} !== {1'b1, 8'h64}) begin
          bad++; $display("FAIL force_b got=%h exp=%h", {y_src, y}, {1'b1, 8'h64});
        end
      end
    end
  endtask

  task automatic test_single_source();
    logic [2:0] bits;
    bits = 3'b101;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      y_ready = 1;
      b_valid = (i < 3); b_last = 1; b_data = (i < 3) ? 8'(bits[i]) : 8'h00;
      @(negedge clk);
      if (i < 3) begin
        total++;
        if (sel !== 1'b1) begin bad++; $display("FAIL single_sel i=%0d got=%b exp=1", i, sel); end
      end
      if (i >= 1 && i <= 3) begin
        total++;
        if ({y_valid, y_src, y} !== {2'b11, 8'(bits[i - 1])}) begin
          bad++; $display("FAIL single_y i=%0d got=%h exp=%h", i, {y_valid, y_src, y}, {2'b11, 8'(bits[i - 1])});
        end
      end
      if (i == 4) begin
        total++;
        if (y_valid !== 1'b0) begin bad++; $display("FAIL single_drain got=%b exp=0", y_valid); end
      end
    end
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_tie();
    test_burst_lock();
    test_backpressure();
    test_forced_release();
    test_single_source();
    @(posedge clk); #1;
    idle_inputs();
    y_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (sb_q.size() != 0) begin
      bad++; $display("FAIL sb_leftover got=%0d exp=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
